// File: rtl/mem_pkg.sv
// Shared types and helpers for the parametrised word store: op encoding, clear FSM states, parity.
package mem_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } mem_state_t;

    // Callers zero-extend their word to this width; zero bits do not change even parity.
    localparam int PARITY_MAX_W = 256;

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mem_clear_ctrl.sv
// Clear sequencer: walks a zero-write across all DEPTH words, one per cycle, after reset or on clr.
// Latency: busy rises the cycle after rst/clr and lasts exactly DEPTH cycles; clr while busy is ignored.
module mem_clear_ctrl
    import mem_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    mem_state_t        r_state;
    mem_state_t        w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (i_clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_busy     = (r_state == ST_CLEAR);
    // No zero-write while reset is held, so reset itself never disturbs stored words.
    assign o_clr_we   = (r_state == ST_CLEAR) && !rst;
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/param_memory_unit.sv
// DEPTH x DATA_W word store with 1-cycle registered read, hardware clear, busy flag and range check.
// Optional per-word even parity with read-time error pulse when MEM_PARITY_EN is defined.
module param_memory_unit
    import mem_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op,
    input  logic              sel,
    input  logic              clr,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] in_bus,
    output logic [DATA_W-1:0] out_bus,
    output logic              rd_valid,
    output logic              busy,
    output logic              addr_err,
    output logic [DATA_W-1:0] stored_value,
    output logic              parity_err
);

    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_out;
    logic              r_rd_valid;
    logic              r_addr_err;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_in_range;
    logic              w_access;
    logic              w_wr_en;
    logic              w_rd_en;
    logic              w_addr_err;

    mem_clear_ctrl #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (clr),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign w_in_range = ({1'b0, address} < DEPTH_EXT);
    // A clear request in the same idle cycle pre-empts any access.
    assign w_access   = sel && !w_busy && !clr && !rst;
    assign w_wr_en    = w_access && (op == OP_WRITE) && w_in_range;
    assign w_rd_en    = w_access && (op == OP_READ) && w_in_range;
    assign w_addr_err = w_access && !w_in_range;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[address] <= in_bus;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_rd_valid <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_en;
            r_addr_err <= w_addr_err;
            if (w_rd_en) begin
                r_out <= r_mem[address];
            end
        end
    end

`ifdef MEM_PARITY_EN
    logic r_par [DEPTH];
    logic r_parity_err;
    logic w_par_mismatch;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_par[w_clr_addr] <= 1'b0;
        end else if (w_wr_en) begin
            r_par[address] <= even_parity(PARITY_MAX_W'(in_bus));
        end
    end

    assign w_par_mismatch = (r_par[address] != even_parity(PARITY_MAX_W'(r_mem[address])));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= w_rd_en && w_par_mismatch;
        end
    end

    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

    assign out_bus      = r_out;
    assign rd_valid     = r_rd_valid;
    assign addr_err     = r_addr_err;
    assign busy         = w_busy;
    assign stored_value = w_in_range ? r_mem[address] : '0;

endmodule

// File: tb/tb_param_memory_unit.sv
// Two instances (DEPTH 8 and 6) share stimulus; directed tables plus random traffic vs a word-level model.
module tb_param_memory_unit;

    localparam int NCYC_RANDOM = 400;
`ifdef MEM_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       op = 1'b0;
    logic       sel = 1'b0;
    logic       clr = 1'b0;
    logic [2:0] address = '0;
    logic [7:0] in_bus = '0;

    logic [7:0] out8, out6, sv8, sv6;
    logic       rv8, rv6, busy8, busy6, ae8, ae6, pe8, pe6;

    always #5 clk = ~clk;

    param_memory_unit #(.DATA_W(8), .DEPTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .op(op), .sel(sel), .clr(clr), .address(address),
        .in_bus(in_bus), .out_bus(out8), .rd_valid(rv8), .busy(busy8),
        .addr_err(ae8), .stored_value(sv8), .parity_err(pe8)
    );

    param_memory_unit #(.DATA_W(8), .DEPTH(6)) u_dut6 (
        .clk(clk), .rst(rst), .op(op), .sel(sel), .clr(clr), .address(address),
        .in_bus(in_bus), .out_bus(out6), .rd_valid(rv6), .busy(busy6),
        .addr_err(ae6), .stored_value(sv6), .parity_err(pe6)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain word arrays plus a "words left to clear" count per instance.
    logic [7:0] m_mem   [2][8];
    logic       m_par   [2][8];
    bit         m_known [2][8];
    logic [7:0] m_out   [2];
    bit         m_out_known [2];
    logic       m_rv [2];
    logic       m_ae [2];
    logic       m_pe [2];
    int         m_left [2];

    function automatic int dep(input int k);
        return (k == 0) ? 8 : 6;
    endfunction

    task automatic chk(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %02h expected %02h", nm, dep(k), $time, act, exp);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int d;
            d = dep(k);
            if (rst) begin
                m_left[k] = d;
                m_out[k] = 8'h00;
                m_out_known[k] = 1'b1;
                m_rv[k] = 1'b0;
                m_ae[k] = 1'b0;
                m_pe[k] = 1'b0;
            end else begin
                m_rv[k] = 1'b0;
                m_ae[k] = 1'b0;
                m_pe[k] = 1'b0;
                if (m_left[k] > 0) begin
                    int idx;
                    idx = d - m_left[k];
                    m_mem[k][idx] = 8'h00;
                    m_par[k][idx] = 1'b0;
                    m_known[k][idx] = 1'b1;
                    m_left[k]--;
                end else if (clr) begin
                    m_left[k] = d;
                end else if (sel) begin
                    if (int'(address) >= d) begin
                        m_ae[k] = 1'b1;
                    end else if (op) begin
                        m_mem[k][address] = in_bus;
                        m_par[k][address] = ^in_bus;
                        m_known[k][address] = 1'b1;
                    end else begin
                        m_rv[k] = 1'b1;
                        m_out[k] = m_mem[k][address];
                        m_out_known[k] = m_known[k][address];
                        m_pe[k] = PAR_ON && (m_par[k][address] != ^m_mem[k][address]);
                    end
                end
            end
        end
    endtask

    // Applies one cycle of inputs, checks stored_value before the edge and all registered outputs after.
    task automatic cycle(input logic s, input logic o, input logic c, input logic r,
                         input logic [2:0] a, input logic [7:0] d);
        logic [7:0] sv_act [2];
        logic [7:0] out_act [2];
        logic       rv_act [2], ae_act [2], busy_act [2], pe_act [2];
        sel = s; op = o; clr = c; rst = r; address = a; in_bus = d;
        #1;
        sv_act[0] = sv8; sv_act[1] = sv6;
        for (int k = 0; k < 2; k++) begin
            if (int'(a) >= dep(k)) chk("stored_value_oor", k, sv_act[k], 8'h00);
            else if (m_known[k][a]) chk("stored_value", k, sv_act[k], m_mem[k][a]);
        end
        model_step();
        @(posedge clk);
        #1;
        out_act[0] = out8; out_act[1] = out6;
        rv_act[0] = rv8; rv_act[1] = rv6;
        ae_act[0] = ae8; ae_act[1] = ae6;
        busy_act[0] = busy8; busy_act[1] = busy6;
        pe_act[0] = pe8; pe_act[1] = pe6;
        for (int k = 0; k < 2; k++) begin
            if (m_out_known[k]) chk("out_bus", k, out_act[k], m_out[k]);
            chk("rd_valid", k, {7'd0, rv_act[k]}, {7'd0, m_rv[k]});
            chk("addr_err", k, {7'd0, ae_act[k]}, {7'd0, m_ae[k]});
            chk("busy", k, {7'd0, busy_act[k]}, {7'd0, m_left[k] > 0});
            chk("parity_err", k, {7'd0, pe_act[k]}, {7'd0, m_pe[k]});
        end
    endtask

    task automatic idle(input logic [2:0] a);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, a, 8'h00);
    endtask

    // Called right after the cycle that started a clear; counts busy cycles per instance.
    task automatic count_busy(input string nm);
        int c8, c6;
        c8 = busy8 ? 1 : 0;
        c6 = busy6 ? 1 : 0;
        for (int i = 0; i < 40 && (busy8 || busy6); i++) begin
            idle(3'd0);
            c8 += busy8 ? 1 : 0;
            c6 += busy6 ? 1 : 0;
        end
        chk(nm, 0, 8'(c8), 8'd8);
        chk(nm, 1, 8'(c6), 8'd6);
    endtask

    task automatic read_all();
        for (int a = 0; a < 8; a++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'(a), 8'h00);
    endtask

    typedef struct {
        logic       s;
        logic       o;
        logic [2:0] a;
        logic [7:0] d;
        logic       rv8;
        logic [7:0] out8;
        logic       ae8;
        logic       rv6;
        logic [7:0] out6;
        logic       ae6;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 3'd3, 8'h55, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 8'h55, 1'b0, 1'b1, 8'h55, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 3'd3, 8'hAA, 1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 3'd3, 8'hAA, 1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 3'd3, 8'hAA, 1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 3'd3, 8'hAA, 1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b0};
        tbl[6] = '{1'b1, 1'b1, 3'd7, 8'h12, 1'b0, 8'h55, 1'b0, 1'b0, 8'h55, 1'b1};
        tbl[7] = '{1'b1, 1'b0, 3'd7, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0, 8'h55, 1'b1};

        for (int k = 0; k < 2; k++) begin
            m_left[k] = 0;
            m_out[k] = 8'h00;
            m_out_known[k] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_known[k][i] = 1'b0;
                m_mem[k][i] = 8'h00;
                m_par[k][i] = 1'b0;
            end
        end

        // Reset for two cycles, then the power-on clear must run DEPTH cycles.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
        count_busy("reset_busy_len");
        read_all();

        foreach (tbl[i]) begin
            cycle(tbl[i].s, tbl[i].o, 1'b0, 1'b0, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_rd_valid", i), 0, {7'd0, rv8}, {7'd0, tbl[i].rv8});
            chk($sformatf("tbl%0d_out_bus", i), 0, out8, tbl[i].out8);
            chk($sformatf("tbl%0d_addr_err", i), 0, {7'd0, ae8}, {7'd0, tbl[i].ae8});
            chk($sformatf("tbl%0d_rd_valid", i), 1, {7'd0, rv6}, {7'd0, tbl[i].rv6});
            chk($sformatf("tbl%0d_out_bus", i), 1, out6, tbl[i].out6);
            chk($sformatf("tbl%0d_addr_err", i), 1, {7'd0, ae6}, {7'd0, tbl[i].ae6});
        end
        for (int a = 0; a < 8; a++) idle(3'(a));

        // Fill with 0xFF, then clr with a colliding write that must be dropped.
        for (int a = 0; a < 8; a++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'(a), 8'hFF);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 8'h12);
        count_busy("clr_busy_len");
        read_all();

        // Refill, start a clear, and reset in its third cycle: the sequence restarts from word 0.
        for (int a = 0; a < 8; a++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'(a), 8'(8'h30 + a));
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 8'h77);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00);
        count_busy("rst_mid_clear_busy_len");
        read_all();

`ifdef MEM_PARITY_EN
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'h5A);
        u_dut8.r_mem[2][0] = ~u_dut8.r_mem[2][0];
        m_mem[0][2][0] = ~m_mem[0][2][0];
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00);
        chk("parity_err_flip", 0, {7'd0, pe8}, 8'd1);
        chk("parity_rd_valid", 0, {7'd0, rv8}, 8'd1);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'h5A);
`else
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 8'h5B);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00);
        chk("parity_err_off", 0, {7'd0, pe8}, 8'd0);
`endif

        for (int i = 0; i < NCYC_RANDOM; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 149) == 0), 3'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/param_memory_unit.md
Name: param_memory_unit

Overview:
Parametrised, clocked successor to the 8x8 select/op memory cell array: DEPTH words of DATA_W bits, addressed read/write under sel/op control. Adds a registered read port with valid strobe, a hardware clear sequencer (after reset or on request), a busy flag, and out-of-range address detection. Sits between the bus controller and the bitcell storage level as the standard word-addressed store.

Parameters:
DATA_W, 8, word width in bits (>=1)
DEPTH, 8, number of words (>=2, need not be a power of two)
ADDR_W, $clog2(DEPTH), address width (derived, not overridden)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-high
op  in  1  1 = write, 0 = read (sampled only when sel=1)
sel  in  1  access request, one access per cycle
clr  in  1  start clearing all words to zero (single-cycle pulse)
address  in  ADDR_W  word address
in_bus  in  DATA_W  write data
out_bus  out  DATA_W  registered read data
rd_valid  out  1  one-cycle pulse: out_bus updated this cycle
busy  out  1  clear sequence in progress; accesses ignored
addr_err  out  1  one-cycle pulse: access with address >= DEPTH
stored_value  out  DATA_W  combinational view of mem[address] (0 if out of range)
parity_err  out  1  see Optional Feature

Behaviour:
- Reset (rst=1 at edge): FSM -> CLEAR, clear counter=0, out_bus=0, rd_valid=0, addr_err=0, parity_err=0, busy=1 from the next cycle. Reset mid-clear restarts the sequence at word 0. Array contents are undefined until the clear finishes.
- FSM states: IDLE and CLEAR.
  - CLEAR: writes 0 to mem[cnt], one word per cycle; cnt counts 0..DEPTH-1; busy=1.
  - CLEAR -> IDLE on the cycle that writes word DEPTH-1. A clear therefore takes exactly DEPTH cycles and busy drops on cycle DEPTH.
  - IDLE -> CLEAR when clr=1; busy=1 from the next cycle.
  - clr while already in CLEAR is ignored; the sequence does not restart.
- In CLEAR: sel, op, in_bus and address are ignored. No rd_valid and no addr_err are produced. out_bus holds its value.
- In IDLE, sel=1, op=1, address<DEPTH: mem[address] <= in_bus at the edge. No rd_valid.
- In IDLE, sel=1, op=0, address<DEPTH: out_bus <= mem[address] at the edge and rd_valid=1 for one cycle. Read latency is 1 clock.
- In IDLE, sel=1, address>=DEPTH: no write. out_bus holds its value. addr_err=1 for one cycle and rd_valid=0.
- sel=0: no access. out_bus holds its last value (latch-retention semantics). rd_valid=0.
- clr and sel in the same IDLE cycle: clr wins and the access is dropped.
- Back-to-back accesses are allowed every cycle. A read at cycle N following a write to the same address at cycle N-1 returns the new data.
- stored_value is combinational and reflects writes from the following cycle. It is for debug/verification only.

Optional Feature:
MEM_PARITY_EN:
- Defined: each word stores an extra even-parity bit (^in_bus) on write; the clear sequence stores parity 0.
- Defined: on a read, parity_err is registered alongside out_bus and pulses 1 with rd_valid when the stored parity does not match the stored data.
- Undefined: no parity storage and parity_err is tied to 0.

Decomposition:
- Package mem_pkg contains:
  - OP_READ=1'b0 and OP_WRITE=1'b1
  - state enum mem_state_t {ST_IDLE, ST_CLEAR}
  - a parity function used when MEM_PARITY_EN is defined
- One sub-module, mem_clear_ctrl, holds the FSM and clear counter. It outputs busy, the clear-write enable and the clear address.
- The array, read register and address checking stay in the top module.

Test Plan:
- Reset, DEPTH=8: rst high for 2 cycles -> busy=1 for exactly 8 cycles after release; then reads of addresses 0..7 all return 0x00, each with rd_valid.
- Write 0x55 to addr 3, then read addr 3 in the next cycle -> out_bus=0x55 and rd_valid=1 one cycle after the read. stored_value=0x55 whenever address=3.
- sel=0 with op toggling and in_bus=0xAA for 4 cycles -> memory unchanged, out_bus holds 0x55, rd_valid=0.
- DEPTH=6: write to addr 7 -> addr_err pulse, no write, and every stored_value of addresses 0..5 unchanged.
- After filling all words with 0xFF, pulse clr together with a sel=1 write of 0x12 to addr 0 -> write dropped, busy for DEPTH cycles, all words read back 0x00. Assert rst in clear cycle 3 -> the sequence restarts and busy lasts a further DEPTH cycles.
- With MEM_PARITY_EN: force-flip a stored data bit of addr 2 through a hierarchical deposit, then read addr 2 -> parity_err=1 coincident with rd_valid. Without the macro -> parity_err stays 0.
